// File: rtl/pie_symbol_decoder_if.sv
// ---------------------------------------------------------------------------
// pie_symbol_decoder_if
// Decoded-symbol bus between the PIE front end (master) and the command
// parser (slave).
//   bit_out    decoded data bit, qualified by bit_valid
//   bit_valid  one-cycle strobe per decoded symbol
//   preamble   TRcal was seen in the current frame (Query)
//   rtcal      captured RTcal interval (clk cycles)
//   trcal      captured TRcal interval, 0 when the frame carried none
//   cmd_done   one-cycle end-of-command strobe
//   frame_err  one-cycle framing error strobe
//   busy       decoder is inside a frame
// ---------------------------------------------------------------------------
interface pie_symbol_decoder_if;
    logic       bit_out;
    logic       bit_valid;
    logic       preamble;
    logic [9:0] rtcal;
    logic [9:0] trcal;
    logic       cmd_done;
    logic       frame_err;
    logic       busy;

    modport master (
        output bit_out, bit_valid, preamble, rtcal, trcal,
               cmd_done, frame_err, busy
    );

    modport slave (
        input  bit_out, bit_valid, preamble, rtcal, trcal,
               cmd_done, frame_err, busy
    );
endinterface

// File: rtl/pie_symbol_decoder.sv
// ---------------------------------------------------------------------------
// pie_symbol_decoder
// Gen2 reader-to-tag PIE front end. Synchronizes the demodulator envelope,
// drives an external 10-bit interval counter, measures delimiter / Tari /
// RTcal / optional TRcal and then slices each symbol into a data bit.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   demod_in    raw envelope (asynchronous), low = reader pulse
//   count       interval counter value
//   overflow    interval counter saturated (count > 750)
//   cnt_clear   registered clear to the interval counter
//   cnt_enable  interval counter enable (= busy)
//   bus         decoded-symbol interface (master side)
//
// Build option
//   PIE_TRCAL_CHECK_EN  when defined, a TRcal candidate is accepted only if
//                       rtcal + rtcal/8 <= sample <= 3*rtcal; otherwise the
//                       frame is rejected with frame_err.
// ---------------------------------------------------------------------------
module pie_symbol_decoder #(
    parameter logic [9:0] DELIM_MIN = 10'd10,
    parameter logic [9:0] DELIM_MAX = 10'd200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  demod_in,
    input  logic [9:0]            count,
    input  logic                  overflow,
    output logic                  cnt_clear,
    output logic                  cnt_enable,
    pie_symbol_decoder_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELIM,
        S_TARI,
        S_RTCAL,
        S_CAL2,
        S_DATA
    } state_t;

    state_t     state_q;
    logic       sync1_q;
    logic       sync2_q;
    logic       hist_q;
    logic       cnt_clear_q;
    logic       bit_out_q;
    logic       bit_valid_q;
    logic       preamble_q;
    logic       cmd_done_q;
    logic       frame_err_q;
    logic       got_bit_q;
    logic [9:0] rtcal_q;
    logic [9:0] trcal_q;

    logic       fall_det;
    logic       rise_det;
    logic [9:0] pivot;
    logic       bit_slice;
    logic       trcal_ok;

    // Edges are taken between the second synchronizer flop and the history
    // flop, so the interval counter value seen alongside an edge is the
    // count for that edge.
    assign fall_det  = hist_q & ~sync2_q;
    assign rise_det  = ~hist_q & sync2_q;
    assign pivot     = {1'b0, rtcal_q[9:1]};
    assign bit_slice = (count >= pivot);

`ifdef PIE_TRCAL_CHECK_EN
    logic [11:0] sample_w;
    logic [11:0] trcal_lo;
    logic [11:0] trcal_hi;

    // 3*rtcal reaches 12 bits, so the whole window is evaluated at 12 bits.
    assign sample_w = {2'b00, count};
    assign trcal_lo = {2'b00, rtcal_q} + {5'b00000, rtcal_q[9:3]};
    assign trcal_hi = {2'b00, rtcal_q} * 12'd3;
    assign trcal_ok = (sample_w >= trcal_lo) && (sample_w <= trcal_hi);
`else
    assign trcal_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
            cnt_clear_q <= 1'b1;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            preamble_q  <= 1'b0;
            cmd_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
            got_bit_q   <= 1'b0;
            rtcal_q     <= 10'd0;
            trcal_q     <= 10'd0;
        end else begin
            sync1_q <= demod_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;

            // Strobes default low; each branch raises at most one of them.
            bit_valid_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_clear_q <= 1'b0;

            if (state_q == S_IDLE) begin
                // Counter held cleared while idle; the clear also stays up
                // for the cycle after the opening falling edge.
                cnt_clear_q <= 1'b1;
                got_bit_q   <= 1'b0;
                if (fall_det) begin
                    state_q <= S_DELIM;
                end
            end else if (overflow) begin
                // Overflow outranks any edge arriving in the same cycle.
                state_q     <= S_IDLE;
                cnt_clear_q <= 1'b1;
                if (state_q == S_DATA && sync2_q) begin
                    // Line parked high after the last symbol: end of command,
                    // provided at least one bit was actually delivered.
                    if (got_bit_q) begin
                        cmd_done_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else if (!(state_q == S_DELIM && sync2_q)) begin
                    frame_err_q <= 1'b1;
                end
            end else if (rise_det) begin
                cnt_clear_q <= 1'b1;
                case (state_q)
                    S_DELIM: begin
                        // An out-of-range delimiter is simply not a frame.
                        if (count >= DELIM_MIN && count <= DELIM_MAX) begin
                            state_q <= S_TARI;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_TARI: begin
                        state_q <= S_RTCAL;
                    end
                    S_RTCAL: begin
                        rtcal_q <= count;
                        state_q <= S_CAL2;
                    end
                    S_CAL2: begin
                        if (count > rtcal_q) begin
                            if (trcal_ok) begin
                                trcal_q    <= count;
                                preamble_q <= 1'b1;
                                state_q    <= S_DATA;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_IDLE;
                            end
                        end else begin
                            // No TRcal: this interval is already data.
                            preamble_q  <= 1'b0;
                            trcal_q     <= 10'd0;
                            bit_out_q   <= bit_slice;
                            bit_valid_q <= 1'b1;
                            got_bit_q   <= 1'b1;
                            state_q     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (count > rtcal_q) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            bit_out_q   <= bit_slice;
                            bit_valid_q <= 1'b1;
                            got_bit_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cnt_clear     = cnt_clear_q;
    assign cnt_enable    = (state_q != S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.preamble  = preamble_q;
    assign bus.rtcal     = rtcal_q;
    assign bus.trcal     = trcal_q;
    assign bus.cmd_done  = cmd_done_q;
    assign bus.frame_err = frame_err_q;

endmodule
